// File: rtl/csa_pkg.sv
// Shared types and constants for the carry-select add scheduler.
package csa_pkg;

    localparam int unsigned NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } csa_state_e;

    typedef logic req_id_t;

endpackage

// File: rtl/csa4_slice.sv
// Combinational 4-bit carry-select adder: both carry candidates per bit, muxed by the
// incoming carry as it propagates.
module csa4_slice (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [3:0] s0, s1, c0, c1;

    always_comb begin
        s0 = a ^ b;
        s1 = ~(a ^ b);
        c0 = a & b;
        c1 = a | b;
    end

    always_comb begin
        logic c;
        c   = cin;
        sum = '0;
        for (int i = 0; i < 4; i++) begin
            sum[i] = c ? s1[i] : s0[i];
            c      = c ? c1[i] : c0[i];
        end
        cout = c;
    end

endmodule

// File: rtl/csa_add_sched.sv
// Two-requester round-robin scheduler that runs each WIDTH-bit add through a single
// 4-bit carry-select slice, one nibble per cycle.
module csa_add_sched
    import csa_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_cin,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_cin,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_sum,
    output logic             res_cout,
    output logic             res_id,
    output logic             busy
);

    localparam int unsigned NIB   = WIDTH / NIB_W;
    localparam int unsigned IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

    csa_state_e       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic             carry_q, carry_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    req_id_t          id_q, id_d;
    req_id_t          last_q, last_d;

    req_id_t          grant;
    logic             accept;
    logic [3:0]       slice_a, slice_b, slice_sum;
    logic             slice_cout;

    // Grant is recomputed every cycle; nothing is held for a requester that drops valid.
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = ~last_q;
        end else if (req1_valid) begin
            grant = 1'b1;
        end
        accept     = !rst && (state_q == IDLE) && (req0_valid || req1_valid);
        req0_ready = accept && !grant;
        req1_ready = accept && grant;
    end

    always_comb begin
        slice_a = a_q[idx_q * NIB_W +: NIB_W];
        slice_b = b_q[idx_q * NIB_W +: NIB_W];
    end

    csa4_slice u_slice (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        id_d    = id_q;
        last_d  = last_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    a_d     = grant ? req1_a : req0_a;
                    b_d     = grant ? req1_b : req0_b;
                    carry_d = grant ? req1_cin : req0_cin;
                    idx_d   = '0;
                    id_d    = grant;
                    last_d  = grant;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[idx_q * NIB_W +: NIB_W] = slice_sum;
                carry_d = slice_cout;
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            id_q    <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            id_q    <= id_d;
            last_q  <= last_d;
        end
    end

    // carry_q holds the final carry-out from the last nibble until the next accept.
    always_comb begin
        res_valid = (state_q == DONE);
        res_sum   = sum_q;
        res_cout  = carry_q;
        res_id    = id_q;
        busy      = (state_q != IDLE);
    end

endmodule

// File: tb/tb_csa_add_sched.sv
// Directed bench for csa_add_sched at WIDTH=16 and WIDTH=4.
module tb_csa_add_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req0_cin;
    logic [15:0] req0_a, req0_b;
    logic        req1_valid, req1_ready, req1_cin;
    logic [15:0] req1_a, req1_b;
    logic        res_valid, res_ready, res_cout, res_id, busy;
    logic [15:0] res_sum;

    logic        v4_valid, v4_ready, v4_cin;
    logic [3:0]  v4_a, v4_b;
    logic        w4_valid, w4_ready, w4_cin;
    logic [3:0]  w4_a, w4_b;
    logic        res4_valid, res4_ready, res4_cout, res4_id, busy4;
    logic [3:0]  res4_sum;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    csa_add_sched #(.WIDTH(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_cin   (req0_cin),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_cin   (req1_cin),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_sum    (res_sum),
        .res_cout   (res_cout),
        .res_id     (res_id),
        .busy       (busy)
    );

    csa_add_sched #(.WIDTH(4)) dut4 (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (v4_valid),
        .req0_ready (v4_ready),
        .req0_a     (v4_a),
        .req0_b     (v4_b),
        .req0_cin   (v4_cin),
        .req1_valid (w4_valid),
        .req1_ready (w4_ready),
        .req1_a     (w4_a),
        .req1_b     (w4_b),
        .req1_cin   (w4_cin),
        .res_valid  (res4_valid),
        .res_ready  (res4_ready),
        .res_sum    (res4_sum),
        .res_cout   (res4_cout),
        .res_id     (res4_id),
        .busy       (busy4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        n_checks++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready: got %b%b expected 00", req0_ready, req1_ready);
        end
        n_checks++;
        if ({res_valid, res_sum, res_cout, res_id, busy} !== 20'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%b s=%h c=%b id=%b busy=%b expected all zero",
                     res_valid, res_sum, res_cout, res_id, busy);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int edges;
        req0_valid = 1'b1;
        req0_a = 16'h1234;
        req0_b = 16'h0FFF;
        req0_cin = 1'b0;
        #1;
        n_checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_grant: got %b%b expected 10", req0_ready, req1_ready);
        end
        tick();
        edges = 1;
        req0_valid = 1'b0;
        req0_a = 16'hDEAD;
        while (!res_valid && edges < 20) begin
            tick();
            edges++;
        end
        n_checks++;
        if (edges !== 5) begin
            n_fail++;
            $display("FAIL basic_latency: got %0d expected 5", edges);
        end
        n_checks++;
        if (res_sum !== 16'h2233 || res_cout !== 1'b0 || res_id !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_result: got %h c=%b id=%b expected 2233 c=0 id=0",
                     res_sum, res_cout, res_id);
        end
        res_ready = 1'b1;
        tick();
        n_checks++;
        if (res_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_release: got v=%b busy=%b expected 0 0", res_valid, busy);
        end
        res_ready = 1'b0;
    endtask

    task automatic test_carry_ripple();
        int edges;
        req1_valid = 1'b1;
        req1_a = 16'hFFFF;
        req1_b = 16'h0000;
        req1_cin = 1'b1;
        #1;
        n_checks++;
        if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL ripple_grant: got %b%b expected 01", req0_ready, req1_ready);
        end
        tick();
        edges = 1;
        req1_valid = 1'b0;
        while (!res_valid && edges < 20) begin
            tick();
            edges++;
        end
        n_checks++;
        if (edges !== 5 || res_sum !== 16'h0000 || res_cout !== 1'b1 || res_id !== 1'b1) begin
            n_fail++;
            $display("FAIL ripple_result: got edges=%0d %h c=%b id=%b expected 5 0000 c=1 id=1",
                     edges, res_sum, res_cout, res_id);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        int acc_n;
        int res_n;
        logic got_id;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req0_valid = 1'b1;
        req0_a = 16'h0100;
        req0_b = 16'h0023;
        req0_cin = 1'b0;
        req1_valid = 1'b1;
        req1_a = 16'hF000;
        req1_b = 16'h1000;
        req1_cin = 1'b1;
        res_ready = 1'b1;
        acc_n = 0;
        res_n = 0;
        #1;
        for (int cyc = 0; cyc < 24; cyc++) begin
            if (req0_ready || req1_ready) begin
                got_id = req1_ready;
                n_checks++;
                if (got_id !== acc_n[0] || cyc !== acc_n * 6) begin
                    n_fail++;
                    $display("FAIL b2b_grant: got id=%b cyc=%0d expected id=%0d cyc=%0d",
                             got_id, cyc, acc_n % 2, acc_n * 6);
                end
                acc_n++;
            end
            if (res_valid) begin
                n_checks++;
                if (res_id !== res_n[0]) begin
                    n_fail++;
                    $display("FAIL b2b_id: got %b expected %0d", res_id, res_n % 2);
                end
                n_checks++;
                if (res_n[0] == 1'b0 && (res_sum !== 16'h0123 || res_cout !== 1'b0)) begin
                    n_fail++;
                    $display("FAIL b2b_sum0: got %h c=%b expected 0123 c=0", res_sum, res_cout);
                end else if (res_n[0] == 1'b1 && (res_sum !== 16'h0001 || res_cout !== 1'b1)) begin
                    n_fail++;
                    $display("FAIL b2b_sum1: got %h c=%b expected 0001 c=1", res_sum, res_cout);
                end
                res_n++;
            end
            tick();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        n_checks++;
        if (acc_n !== 4 || res_n !== 4) begin
            n_fail++;
            $display("FAIL b2b_count: got acc=%0d res=%0d expected 4 4", acc_n, res_n);
        end
        res_ready = 1'b0;
        tick();
    endtask

    task automatic test_hold();
        int edges;
        req0_valid = 1'b1;
        req0_a = 16'hABCD;
        req0_b = 16'h1111;
        req0_cin = 1'b0;
        tick();
        edges = 1;
        req0_valid = 1'b0;
        req1_valid = 1'b1;
        req1_a = 16'h0F0F;
        req1_b = 16'h0101;
        req1_cin = 1'b0;
        while (!res_valid && edges < 20) begin
            tick();
            edges++;
        end
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (res_valid !== 1'b1 || res_sum !== 16'hBCDE || res_cout !== 1'b0 ||
                res_id !== 1'b0 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL hold_result: got v=%b %h c=%b id=%b busy=%b expected 1 BCDE 0 0 1",
                         res_valid, res_sum, res_cout, res_id, busy);
            end
            n_checks++;
            if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_ready: got %b%b expected 00", req0_ready, req1_ready);
            end
            tick();
        end
        res_ready = 1'b1;
        tick();
        n_checks++;
        if (busy !== 1'b0 || res_valid !== 1'b0 || req1_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_release: got busy=%b v=%b r1=%b expected 0 0 1",
                     busy, res_valid, req1_ready);
        end
        req1_valid = 1'b0;
        res_ready = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        int seen;
        int edges;
        req0_valid = 1'b1;
        req0_a = 16'h5555;
        req0_b = 16'h5555;
        req0_cin = 1'b1;
        tick();
        req0_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        n_checks++;
        if ({res_valid, res_sum, res_cout, res_id, busy} !== 20'h0) begin
            n_fail++;
            $display("FAIL midrst_outputs: got v=%b s=%h c=%b id=%b busy=%b expected all zero",
                     res_valid, res_sum, res_cout, res_id, busy);
        end
        rst = 1'b0;
        res_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (res_valid) seen++;
            tick();
        end
        n_checks++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL midrst_noresult: got %0d result cycles expected 0", seen);
        end
        res_ready = 1'b0;
        req0_valid = 1'b1;
        req0_a = 16'h0001;
        req0_b = 16'h0001;
        req0_cin = 1'b0;
        tick();
        edges = 1;
        req0_valid = 1'b0;
        while (!res_valid && edges < 20) begin
            tick();
            edges++;
        end
        n_checks++;
        if (edges !== 5 || res_sum !== 16'h0002 || res_cout !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_after: got edges=%0d %h c=%b expected 5 0002 c=0",
                     edges, res_sum, res_cout);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    task automatic test_width4();
        int edges;
        v4_valid = 1'b1;
        v4_a = 4'h9;
        v4_b = 4'h8;
        v4_cin = 1'b1;
        #1;
        n_checks++;
        if (v4_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL w4_grant: got %b expected 1", v4_ready);
        end
        tick();
        edges = 1;
        v4_valid = 1'b0;
        while (!res4_valid && edges < 20) begin
            tick();
            edges++;
        end
        n_checks++;
        if (edges !== 2 || res4_sum !== 4'h2 || res4_cout !== 1'b1 || res4_id !== 1'b0) begin
            n_fail++;
            $display("FAIL w4_result: got edges=%0d %h c=%b id=%b expected 2 2 c=1 id=0",
                     edges, res4_sum, res4_cout, res4_id);
        end
        res4_ready = 1'b1;
        tick();
        n_checks++;
        if (res4_valid !== 1'b0 || busy4 !== 1'b0) begin
            n_fail++;
            $display("FAIL w4_release: got v=%b busy=%b expected 0 0", res4_valid, busy4);
        end
        res4_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_cin = 1'b0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_cin = 1'b0;
        res_ready = 1'b0;
        v4_valid = 1'b0; v4_a = '0; v4_b = '0; v4_cin = 1'b0;
        w4_valid = 1'b0; w4_a = '0; w4_b = '0; w4_cin = 1'b0;
        res4_ready = 1'b0;
        tick();
        tick();
        test_reset();
        test_basic();
        test_carry_ripple();
        test_back_to_back();
        test_hold();
        test_reset_mid();
        test_width4();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/csa_add_sched.md
# csa_add_sched

Shared-adder scheduler for the carry-select arithmetic path. Two requesters submit WIDTH-bit additions. The block arbitrates them round-robin and runs the winner through a single 4-bit carry-select adder slice, one nibble per cycle, with the carry registered between nibbles. It returns the sum, carry-out and requester id over a valid/ready result port. It is the sequencing wrapper the team uses wherever wide adds are too infrequent to justify a full-width adder.

## Interface
- WIDTH, 16, operand/sum width; multiple of 4, minimum 4.
- NIB (derived, not overridable), WIDTH/4, number of nibble steps.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 accepted this cycle.
- req0_a, req0_b  in  WIDTH  requester 0 operands.
- req0_cin  in  1  requester 0 carry-in.
- req1_valid / req1_ready / req1_a / req1_b / req1_cin: same for requester 1.
- res_valid  out  1  result available.
- res_ready  in  1  consumer takes result.
- res_sum  out  WIDTH  (a+b+cin) mod 2^WIDTH.
- res_cout  out  1  carry out of bit WIDTH-1.
- res_id  out  1  requester that issued the result.
- busy  out  1  high in RUN and DONE.

## Operation
- FSM states: IDLE, RUN, DONE.
- **IDLE:** grant logic is combinational on the valids.
  - Only one requester valid: that requester is granted.
  - Both valid: the requester not in last_grant is granted.
  - The granted requester's ready is high; the other ready is low.
  - On handshake (valid & ready), capture a, b, cin and id, set nib_idx=0, set last_grant=id, and go to RUN.
- **RUN:** each cycle the slice adds a[4k+3:4k], b[4k+3:4k] and carry_reg, where k=nib_idx.
  - Slice sum is written to sum_reg[4k+3:4k]; carry_reg takes the slice carry-out.
  - carry_reg is loaded with cin on accept.
  - When nib_idx==NIB-1, go to DONE; otherwise nib_idx increments.
- **DONE:** res_valid=1.
  - res_sum, res_cout and res_id are held stable while res_ready=0.
  - On res_ready=1, go to IDLE.
- Both req*_ready are 0 outside IDLE.
- A requester may drop valid before it is granted; no grant is held across cycles.
- Operands are sampled only on the handshake cycle and may change afterwards.
- Arithmetic is unsigned. The result is identical to a single-cycle WIDTH-bit add with carry-in, where res_cout is bit WIDTH of the full sum.

## Timing
- Reset values:
  - Registered state: state=IDLE, res_valid=0, res_sum=0, res_cout=0, res_id=0, busy=0, last_grant=1 (so req0 wins the first tie), nib_idx=0, carry_reg=0.
  - Combinational readies: req0_ready=0 and req1_ready=0 while rst is high.
- Latency: handshake in cycle T; RUN occupies T+1..T+NIB; res_valid is first high in T+NIB+1.
- Throughput: one operation per NIB+2 cycles with res_ready held high. The result is consumed in DONE, IDLE follows, and the next accept happens in that IDLE cycle.
- Reset mid-operation: the operation is discarded, no result is produced, and all outputs take their reset values the cycle after rst is sampled.
- res_ready high outside DONE is ignored.
- nib_idx width is clog2(NIB), minimum 1. With NIB=1, RUN lasts exactly one cycle.

## Structure
- Package csa_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - the constant NIB_W=4;
  - the requester-id type (1 bit).
- One sub-module, csa4_slice: a combinational 4-bit carry-select adder.
  - Ports: a[3:0], b[3:0], cin, sum[3:0], cout.
  - Internally it computes carry-0 and carry-1 candidates per bit and muxes them by the incoming carry.
- The scheduler instantiates exactly one csa4_slice. The operand nibble mux is selected by nib_idx.

## Test plan
1. WIDTH=16, req0 a=0x1234, b=0x0FFF, cin=0, accepted at T → res_valid first at T+5 with res_sum=0x2233, res_cout=0, res_id=0.
2. req1 a=0xFFFF, b=0x0000, cin=1 (carry ripples through all nibbles) → res_sum=0x0000, res_cout=1, res_id=1.
3. Both requesters valid continuously from reset, res_ready=1 → grants alternate 0,1,0,1; each result's res_id matches its grant, with one result per 6 cycles.
4. Hold res_ready=0 for 3 cycles in DONE → res_sum/res_cout/res_id stable, res_valid=1, both readies 0, no new accept; IDLE follows the cycle after res_ready=1.
5. Assert rst during RUN at nib_idx=2 → next cycle state=IDLE, busy=0, res_valid=0, and no result is emitted. A subsequent req0 0x0001+0x0001 gives res_sum=0x0002.
6. WIDTH=4, a=0x9, b=0x8, cin=1, accepted at T → res_valid at T+2 with res_sum=0x2, res_cout=1.
